trashbin_mem_arbiter: RTL and testbench

- Two-requester arbiter sharing one memory port, with the CPU-side handshake of strobe plus ReadOK/WriteOK.
- Requester 0 is the Trashbin core (fetch, load and store). Requester 1 is the debug/loader port.
- Serialises one transaction at a time, selects by round-robin (or fixed priority), and returns read data and a per-requester acknowledge.
- A watchdog completes any transaction that memory never acknowledges, flagging it with an error.

---
 rtl/trashbin_bus_pkg.sv | 25 ++
 rtl/trashbin_mem_arbiter_if.sv | 48 ++++
 rtl/trashbin_rr_picker.sv | 26 ++
 rtl/trashbin_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_trashbin_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/trashbin_bus_pkg.sv
// Shared types and constants for the Trashbin memory arbiter slice.
// Latency: n/a (types, constants and one constant function only).
// Backpressure: n/a.
package trashbin_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arbState_t;

    localparam int REQ_CORE   = 0;
    localparam int REQ_DEBUG  = 1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Watchdog counter width: enough to hold the limit itself, never less than 1 bit.
    function automatic int wdogWidth(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/trashbin_mem_arbiter_if.sv
// Bundles the requester-side and memory-side signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requests are levels held until ReqAck; memory stalls by withholding ReadOK/WriteOK.
// Ports: Req* from both requesters (packed per-requester slices), Mem* to/from memory,
//        Busy/GrantId status. slave = arbiter view, master = requesters + memory view.
interface trashbin_mem_arbiter_if
    import trashbin_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [1:0]          ReqValid;
    logic [1:0]          ReqWrite;
    logic [2*ADDR_W-1:0] ReqAddr;
    logic [2*DATA_W-1:0] ReqWData;
    logic [1:0]          ReqAck;
    logic                ReqErr;
    logic [DATA_W-1:0]   ReqRData;

    logic [ADDR_W-1:0]   MemAddr;
    logic [DATA_W-1:0]   MemWData;
    logic                MemRead;
    logic                MemWrite;
    logic [DATA_W-1:0]   MemDataRead;
    logic                MemReadOK;
    logic                MemWriteOK;

    logic                Busy;
    logic                GrantId;

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData,
        input  MemDataRead, MemReadOK, MemWriteOK,
        output ReqAck, ReqErr, ReqRData,
        output MemAddr, MemWData, MemRead, MemWrite,
        output Busy, GrantId
    );

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData,
        output MemDataRead, MemReadOK, MemWriteOK,
        input  ReqAck, ReqErr, ReqRData,
        input  MemAddr, MemWData, MemRead, MemWrite,
        input  Busy, GrantId
    );

endinterface

// File: rtl/trashbin_rr_picker.sv
// Two-way request picker: single requester wins outright, ties go round-robin or to requester 0.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: ReqValid (per-requester level), LastGrant (previous winner) -> Winner, Any.
module trashbin_rr_picker #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic [1:0] ReqValid,
    input  logic       LastGrant,
    output logic       Winner,
    output logic       Any
);

    always_comb begin
        Any    = |ReqValid;
        Winner = 1'b0;
        case (ReqValid)
            2'b01:   Winner = 1'b0;
            2'b10:   Winner = 1'b1;
            // On a tie, round-robin hands the grant to whoever did not have it last.
            2'b11:   Winner = ROUND_ROBIN ? ~LastGrant : 1'b0;
            default: Winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/trashbin_mem_arbiter.sv
// Serialises core and debug requests onto one strobe/OK memory port, with a timeout watchdog.
// Latency: request->strobe 1 cycle, OK->ReqAck 1 cycle; minimum 3 cycles per transaction.
// Backpressure: requests wait (level held) while Busy; memory stalls by withholding the matching OK.
// Ports: CoreClock, CoreResetN (async active-low), Bus (slave modport: Req*, Mem*, Busy, GrantId).
module trashbin_mem_arbiter
    import trashbin_bus_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit ROUND_ROBIN    = 1'b1
) (
    input  logic                  CoreClock,
    input  logic                  CoreResetN,
    trashbin_mem_arbiter_if.slave Bus
);

    localparam int              WD_W    = wdogWidth(TIMEOUT_CYCLES);
    localparam bit              WD_ON   = (TIMEOUT_CYCLES != 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);

    arbState_t         state,    stateN;
    logic [ADDR_W-1:0] addrQ,    addrN;
    logic [DATA_W-1:0] wdataQ,   wdataN;
    logic              readQ,    readN;
    logic              writeQ,   writeN;
    logic              isWriteQ, isWriteN;
    logic [1:0]        ackQ,     ackN;
    logic              errQ,     errN;
    logic [DATA_W-1:0] rdataQ,   rdataN;
    logic              grantQ,   grantN;
    logic              lastQ,    lastN;
    logic              busyQ,    busyN;
    logic [WD_W-1:0]   wdogQ,    wdogN;

    logic winner;
    logic anyReq;
    logic okHit;

    trashbin_rr_picker #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) uPicker (
        .ReqValid  (Bus.ReqValid),
        .LastGrant (lastQ),
        .Winner    (winner),
        .Any       (anyReq)
    );

    // Only the OK matching the latched transaction type counts.
    assign okHit = isWriteQ ? Bus.MemWriteOK : Bus.MemReadOK;

    always_comb begin
        stateN   = state;
        addrN    = addrQ;
        wdataN   = wdataQ;
        readN    = readQ;
        writeN   = writeQ;
        isWriteN = isWriteQ;
        ackN     = '0;
        errN     = errQ;
        rdataN   = rdataQ;
        grantN   = grantQ;
        lastN    = lastQ;
        wdogN    = wdogQ;

        unique case (state)
            IDLE: begin
                if (anyReq) begin
                    stateN   = BUSY;
                    addrN    = winner ? Bus.ReqAddr[ADDR_W +: ADDR_W]  : Bus.ReqAddr[0 +: ADDR_W];
                    wdataN   = winner ? Bus.ReqWData[DATA_W +: DATA_W] : Bus.ReqWData[0 +: DATA_W];
                    isWriteN = Bus.ReqWrite[winner];
                    writeN   = Bus.ReqWrite[winner];
                    readN    = ~Bus.ReqWrite[winner];
                    grantN   = winner;
                    lastN    = winner;
                    wdogN    = '0;
                end
            end
            BUSY: begin
                if (okHit) begin
                    stateN       = DONE;
                    rdataN       = isWriteQ ? '0 : Bus.MemDataRead;
                    errN         = 1'b0;
                    readN        = 1'b0;
                    writeN       = 1'b0;
                    ackN[grantQ] = 1'b1;
                end else begin
                    // Saturates at the limit rather than wrapping.
                    if (wdogQ != WD_MAX) begin
                        wdogN = wdogQ + 1'b1;
                    end
                    if (WD_ON && (wdogQ == WD_LAST)) begin
                        stateN       = DONE;
                        rdataN       = '0;
                        errN         = 1'b1;
                        readN        = 1'b0;
                        writeN       = 1'b0;
                        ackN[grantQ] = 1'b1;
                    end
                end
            end
            // Ack is already on the wire; requests are ignored here so the requester
            // can update its request on the same edge it samples the ack.
            DONE:    stateN = IDLE;
            default: stateN = IDLE;
        endcase

        busyN = (stateN != IDLE);
    end

    always_ff @(posedge CoreClock or negedge CoreResetN) begin
        if (!CoreResetN) begin
            state    <= IDLE;
            addrQ    <= '0;
            wdataQ   <= '0;
            readQ    <= 1'b0;
            writeQ   <= 1'b0;
            isWriteQ <= 1'b0;
            ackQ     <= '0;
            errQ     <= 1'b0;
            rdataQ   <= '0;
            grantQ   <= 1'b0;
            lastQ    <= 1'b1;
            busyQ    <= 1'b0;
            wdogQ    <= '0;
        end else begin
            state    <= stateN;
            addrQ    <= addrN;
            wdataQ   <= wdataN;
            readQ    <= readN;
            writeQ   <= writeN;
            isWriteQ <= isWriteN;
            ackQ     <= ackN;
            errQ     <= errN;
            rdataQ   <= rdataN;
            grantQ   <= grantN;
            lastQ    <= lastN;
            busyQ    <= busyN;
            wdogQ    <= wdogN;
        end
    end

    assign Bus.MemAddr  = addrQ;
    assign Bus.MemWData = wdataQ;
    assign Bus.MemRead  = readQ;
    assign Bus.MemWrite = writeQ;
    assign Bus.ReqAck   = ackQ;
    assign Bus.ReqErr   = errQ;
    assign Bus.ReqRData = rdataQ;
    assign Bus.GrantId  = grantQ;
    assign Bus.Busy     = busyQ;

endmodule

// File: tb/tb_trashbin_mem_arbiter.sv
// Bench for the memory arbiter: scoreboarded acks on a round-robin/4-cycle-timeout instance
// and a fixed-priority/no-watchdog instance.
// Latency/backpressure exercised: 0-wait and delayed OKs, ignored wrong-type OK, timeouts, reset abort.
module tb_trashbin_mem_arbiter;

    typedef struct packed {
        logic [1:0]  ack;
        logic        err;
        logic [31:0] rdata;
    } expRec_t;

    logic CoreClock  = 1'b0;
    logic CoreResetN = 1'b0;
    int   cyc        = 0;
    int   checks     = 0;
    int   failures   = 0;

    expRec_t expA[$];
    expRec_t expB[$];

    trashbin_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) busA ();
    trashbin_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) busB ();

    trashbin_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4), .ROUND_ROBIN(1'b1)
    ) dutA (
        .CoreClock  (CoreClock),
        .CoreResetN (CoreResetN),
        .Bus        (busA)
    );

    trashbin_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(0), .ROUND_ROBIN(1'b0)
    ) dutB (
        .CoreClock  (CoreClock),
        .CoreResetN (CoreResetN),
        .Bus        (busB)
    );

    always #5 CoreClock = ~CoreClock;
    always @(posedge CoreClock) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memFn(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Scoreboard monitors: every ack pulse must match the oldest expected record.
    always @(negedge CoreClock) begin
        if (CoreResetN && busA.ReqAck != 2'b00) begin
            if (expA.size() == 0) begin
                checkVal("ackA_unexpected", {62'd0, busA.ReqAck}, 64'd0);
            end else begin
                expRec_t e;
                e = expA.pop_front();
                checkVal("ackA_id",    {62'd0, busA.ReqAck},   {62'd0, e.ack});
                checkVal("ackA_err",   {63'd0, busA.ReqErr},   {63'd0, e.err});
                checkVal("ackA_rdata", {32'd0, busA.ReqRData}, {32'd0, e.rdata});
            end
        end
    end

    always @(negedge CoreClock) begin
        if (CoreResetN && busB.ReqAck != 2'b00) begin
            if (expB.size() == 0) begin
                checkVal("ackB_unexpected", {62'd0, busB.ReqAck}, 64'd0);
            end else begin
                expRec_t e;
                e = expB.pop_front();
                checkVal("ackB_id",    {62'd0, busB.ReqAck},   {62'd0, e.ack});
                checkVal("ackB_rdata", {32'd0, busB.ReqRData}, {32'd0, e.rdata});
            end
        end
    end

    task automatic waitAckA(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge CoreClock);
            if (busA.ReqAck != 2'b00) seen = 1'b1;
        end
        checkVal("ackA_arrived", {63'd0, seen}, 64'd1);
    endtask

    initial begin
        bit seen;
        int reqCyc;
        int acks;
        int lastAck;
        int strobes;

        busA.ReqValid = '0; busA.ReqWrite = '0; busA.ReqAddr = '0; busA.ReqWData = '0;
        busA.MemDataRead = '0; busA.MemReadOK = 1'b0; busA.MemWriteOK = 1'b0;
        busB.ReqValid = '0; busB.ReqWrite = '0; busB.ReqAddr = '0; busB.ReqWData = '0;
        busB.MemDataRead = '0; busB.MemReadOK = 1'b0; busB.MemWriteOK = 1'b0;

        // Reset state
        repeat (2) @(negedge CoreClock);
        checkVal("rst_memread",  {63'd0, busA.MemRead},  64'd0);
        checkVal("rst_memwrite", {63'd0, busA.MemWrite}, 64'd0);
        checkVal("rst_memaddr",  {32'd0, busA.MemAddr},  64'd0);
        checkVal("rst_ack",      {62'd0, busA.ReqAck},   64'd0);
        checkVal("rst_busy",     {63'd0, busA.Busy},     64'd0);
        checkVal("rst_grant",    {63'd0, busA.GrantId},  64'd0);
        checkVal("rst_rdata",    {32'd0, busA.ReqRData}, 64'd0);
        CoreResetN = 1'b1;
        @(negedge CoreClock);

        // Single core read, OK two cycles after the strobe rises
        busA.ReqValid = 2'b01; busA.ReqWrite = 2'b00; busA.ReqAddr[31:0] = 32'h10;
        expA.push_back('{ack: 2'b01, err: 1'b0, rdata: 32'hDEADBEEF});
        reqCyc = cyc;
        @(negedge CoreClock);
        checkVal("rd_strobe",   {63'd0, busA.MemRead},  64'd1);
        checkVal("rd_nowrite",  {63'd0, busA.MemWrite}, 64'd0);
        checkVal("rd_addr",     {32'd0, busA.MemAddr},  64'h10);
        checkVal("rd_busy",     {63'd0, busA.Busy},     64'd1);
        @(negedge CoreClock);
        checkVal("rd_strobe_hold", {63'd0, busA.MemRead}, 64'd1);
        @(negedge CoreClock);
        busA.MemReadOK = 1'b1; busA.MemDataRead = 32'hDEADBEEF;
        waitAckA(2, seen);
        busA.MemReadOK = 1'b0; busA.ReqValid = 2'b00;
        checkVal("rd_latency",      (cyc - reqCyc + 1), 64'd5);
        checkVal("rd_strobe_done",  {63'd0, busA.MemRead}, 64'd0);
        @(negedge CoreClock);

        // Debug write with a stray ReadOK that must be ignored
        busA.ReqValid = 2'b10; busA.ReqWrite = 2'b10;
        busA.ReqAddr[63:32] = 32'h20; busA.ReqWData[63:32] = 32'h55;
        busA.MemDataRead = 32'h1111_2222;
        expA.push_back('{ack: 2'b10, err: 1'b0, rdata: 32'h0});
        @(negedge CoreClock);
        checkVal("wr_strobe",  {63'd0, busA.MemWrite}, 64'd1);
        checkVal("wr_noread",  {63'd0, busA.MemRead},  64'd0);
        checkVal("wr_addr",    {32'd0, busA.MemAddr},  64'h20);
        checkVal("wr_wdata",   {32'd0, busA.MemWData}, 64'h55);
        checkVal("wr_grant",   {63'd0, busA.GrantId},  64'd1);
        busA.MemReadOK = 1'b1;
        @(negedge CoreClock);
        busA.MemReadOK = 1'b0;
        checkVal("wr_strobe_hold", {63'd0, busA.MemWrite}, 64'd1);
        checkVal("wr_wdata_hold",  {32'd0, busA.MemWData}, 64'h55);
        busA.MemWriteOK = 1'b1;
        waitAckA(2, seen);
        busA.MemWriteOK = 1'b0; busA.ReqValid = 2'b00; busA.ReqWrite = 2'b00;
        @(negedge CoreClock);

        // Contention with 0-wait memory: order 0,1,0,1, one ack every 3 cycles
        busA.ReqValid = 2'b11; busA.ReqAddr = {32'h200, 32'h100};
        for (int k = 0; k < 4; k++) begin
            expA.push_back('{ack: (k % 2 == 0) ? 2'b01 : 2'b10, err: 1'b0,
                             rdata: memFn((k % 2 == 0) ? 32'h100 : 32'h200)});
        end
        acks = 0; lastAck = -1;
        for (int i = 0; i < 40 && acks < 4; i++) begin
            @(negedge CoreClock);
            if (busA.ReqAck != 2'b00) begin
                acks++;
                if (lastAck >= 0) checkVal("rr_spacing", (cyc - lastAck), 64'd3);
                lastAck = cyc;
            end
            busA.MemReadOK   = busA.MemRead;
            busA.MemDataRead = busA.MemRead ? memFn(busA.MemAddr) : 32'h0;
        end
        busA.ReqValid = 2'b00; busA.MemReadOK = 1'b0;
        checkVal("rr_ack_count", acks, 64'd4);
        @(negedge CoreClock);

        // Fixed priority instance: requester 0 wins every tie
        busB.ReqValid = 2'b11; busB.ReqAddr = {32'h200, 32'h100};
        for (int k = 0; k < 3; k++) expB.push_back('{ack: 2'b01, err: 1'b0, rdata: memFn(32'h100)});
        acks = 0;
        for (int i = 0; i < 30 && acks < 3; i++) begin
            @(negedge CoreClock);
            if (busB.ReqAck != 2'b00) acks++;
            busB.MemReadOK   = busB.MemRead;
            busB.MemDataRead = busB.MemRead ? memFn(busB.MemAddr) : 32'h0;
        end
        busB.ReqValid = 2'b00; busB.MemReadOK = 1'b0;
        checkVal("fp_ack_count", acks, 64'd3);
        @(negedge CoreClock);

        // Timeout: no OK ever arrives, error completion after 4 BUSY cycles
        busA.ReqValid = 2'b01; busA.ReqAddr[31:0] = 32'h30; busA.MemDataRead = 32'hFFFF_FFFF;
        expA.push_back('{ack: 2'b01, err: 1'b1, rdata: 32'h0});
        strobes = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CoreClock);
            if (busA.MemRead) strobes++;
            if (busA.ReqAck != 2'b00) seen = 1'b1;
        end
        busA.ReqValid = 2'b00;
        checkVal("to_seen",        {63'd0, seen}, 64'd1);
        checkVal("to_busy_cycles", strobes,       64'd4);
        @(negedge CoreClock);

        // OK on the 4th BUSY cycle beats the watchdog
        busA.ReqValid = 2'b01; busA.ReqAddr[31:0] = 32'h34;
        expA.push_back('{ack: 2'b01, err: 1'b0, rdata: 32'h1234_5678});
        repeat (3) @(negedge CoreClock);
        checkVal("to_ok_still_busy", {63'd0, busA.MemRead}, 64'd1);
        @(negedge CoreClock);
        busA.MemReadOK = 1'b1; busA.MemDataRead = 32'h1234_5678;
        waitAckA(2, seen);
        busA.MemReadOK = 1'b0; busA.ReqValid = 2'b00;
        @(negedge CoreClock);

        // Reset in the 2nd BUSY cycle: strobe drops at once, no ack
        busA.ReqValid = 2'b01; busA.ReqAddr[31:0] = 32'h40;
        @(negedge CoreClock);
        @(posedge CoreClock);
        #2;
        CoreResetN = 1'b0;
        #1;
        checkVal("rst_mid_memread", {63'd0, busA.MemRead}, 64'd0);
        checkVal("rst_mid_busy",    {63'd0, busA.Busy},    64'd0);
        busA.ReqValid = 2'b11; busA.ReqAddr = {32'h200, 32'h100};
        @(negedge CoreClock);
        CoreResetN = 1'b1;
        expA.push_back('{ack: 2'b01, err: 1'b0, rdata: memFn(32'h100)});
        @(negedge CoreClock);
        checkVal("rst_after_grant", {63'd0, busA.GrantId}, 64'd0);
        checkVal("rst_after_addr",  {32'd0, busA.MemAddr}, 64'h100);
        acks = 0;
        for (int i = 0; i < 10 && acks < 1; i++) begin
            busA.MemReadOK   = busA.MemRead;
            busA.MemDataRead = busA.MemRead ? memFn(busA.MemAddr) : 32'h0;
            @(negedge CoreClock);
            if (busA.ReqAck != 2'b00) acks++;
        end
        busA.ReqValid = 2'b00; busA.MemReadOK = 1'b0;
        checkVal("rst_after_acks", acks, 64'd1);
        repeat (2) @(negedge CoreClock);

        checkVal("expA_left", expA.size(), 64'd0);
        checkVal("expB_left", expB.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
